cb_serial_subtractor: RTL

Multi-cycle WIDTH-bit subtractor computing a − b − bin one 4-bit slice per clock, least-significant slice first, through a single carry-bypass slice in subtract form. It is the subtract-direction counterpart of the carry-bypass adder family. It sits behind a valid/ready handshake on both sides, so a datapath can issue subtractions without instantiating a full-width bypass chain.

---
 rtl/cb_pkg.sv | 12 +
 rtl/cb_sub_slice_4.sv | 29 ++
 rtl/cb_serial_subtractor.sv | 111 +++++++++++
 3 files changed

// File: rtl/cb_pkg.sv
// Shared constants and FSM encoding for the carry-bypass serial subtractor.
package cb_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cb_sub_slice_4.sv
// Combinational 4-bit subtract slice: a + nb + cin with a carry-bypass mux.
// The caller supplies nb = ~b and cin = ~borrow, so cout is the inverted borrow.
module cb_sub_slice_4 (
  input  logic [3:0] a,
  input  logic [3:0] nb,
  input  logic       cin,
  output logic [3:0] d,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ nb;
  assign g = a & nb;

  // Ripple chain; d uses the ripple carries, cout takes the bypass when all bits propagate.
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign d    = p ^ c[3:0];
  assign cout = (&p) ? cin : c[4];

endmodule

// File: rtl/cb_serial_subtractor.sv
// Serial WIDTH-bit subtractor: a - b - bin, one 4-bit slice per clock, LS slice first.
// WIDTH must be a multiple of 4 and at least 8.
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | processing slice k each clock
// DONE  | result held, out_valid high until out_ready
module cb_serial_subtractor
  import cb_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NSL = WIDTH / SLICE_W;
  localparam int KW  = $clog2(NSL);
  localparam int MSB = WIDTH - 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSL - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0]   a_q, nb_q, diff_q;
  logic               carry_q, bout_q, ovf_q;
  logic [KW-1:0]      k_q;
  logic [SLICE_W-1:0] sl_a, sl_nb, sl_d;
  logic               sl_c;
  logic               accept;

  assign accept = in_valid && (state_q == IDLE);
  assign sl_a   = a_q[k_q*SLICE_W +: SLICE_W];
  assign sl_nb  = nb_q[k_q*SLICE_W +: SLICE_W];

  cb_sub_slice_4 u_slice (
    .a    (sl_a),
    .nb   (sl_nb),
    .cin  (carry_q),
    .d    (sl_d),
    .cout (sl_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (k_q == K_LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, per-slice accumulation, and result flags on the last slice.
  // The flags use the last slice's d directly since diff[MSB] is written on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      nb_q    <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      nb_q    <= ~b;
      carry_q <= ~bin;
      k_q     <= '0;
      diff_q  <= '0;
    end else if (state_q == RUN) begin
      diff_q[k_q*SLICE_W +: SLICE_W] <= sl_d;
      carry_q <= sl_c;
      k_q     <= k_q + 1'b1;
      if (k_q == K_LAST) begin
        bout_q <= ~sl_c;
        ovf_q  <= (a_q[MSB] ^ ~nb_q[MSB]) & (a_q[MSB] ^ sl_d[SLICE_W-1]);
      end
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule
